multicycle_sequencer: RTL and testbench

//  Control FSM that runs the RISC-V datapath as a multi-cycle machine with one shared memory port.

---
 rtl/multicycle_sequencer_if.sv | 37 +++
 rtl/multicycle_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Control bus between the multi-cycle sequencer and the datapath/memory side.
// The master modport is the sequencer; the slave modport is the datapath and memory.
interface multicycle_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal;
    logic             mem_err;
    logic [CNT_W-1:0] retire_count;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, mem_err,
               retire_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, mem_err,
               retire_count
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RISC-V control FSM sharing one memory port for fetch and data,
// with a memory wait timeout and a retired-instruction counter.
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4 on completion
//   DECODE | latch opcode class, precompute branch target into ALUOut
//   EXEC   | address / ALU op / branch compare
//   MEM    | data load or store at ALUOut
//   WB     | register file write from ALUOut or memory data
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_sequencer_if.master bus
);
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_I   = 3'd1,
        CL_LD  = 3'd2,
        CL_ST  = 3'd3,
        CL_BEQ = 3'd4,
        CL_ILL = 3'd5
    } class_e;

    state_e             state_q, state_d;
    class_e             class_q, class_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   retire_q, retire_d;

    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
    logic       reg_write, mem_to_reg, alu_src_a, illegal, mem_err;
    logic [1:0] alu_src_b, alu_op;
    logic       retire, tmo_last, waiting;
    class_e     dec_class;

    always_comb begin
        unique case (bus.opcode)
            7'b0110011: dec_class = CL_R;
            7'b0010011: dec_class = CL_I;
            7'b0000011: dec_class = CL_LD;
            7'b0100011: dec_class = CL_ST;
            7'b1100011: dec_class = CL_BEQ;
            default:    dec_class = CL_ILL;
        endcase
    end

    // Reaching this count on a further wait cycle is the MEM_TIMEOUT-th consecutive wait.
    assign tmo_last = (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (tmo_last) begin
                    mem_err = 1'b1;
                    state_d = FETCH;
                end
            end
            DECODE: begin
                alu_src_b = 2'b10;
                class_d   = dec_class;
                if (dec_class == CL_ILL) begin
                    illegal = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                case (class_q)
                    CL_R: begin
                        alu_op  = 2'b10;
                        state_d = WB;
                    end
                    CL_I: begin
                        alu_src_b = 2'b10;
                        alu_op    = 2'b10;
                        state_d   = WB;
                    end
                    CL_LD, CL_ST: begin
                        alu_src_b = 2'b10;
                        state_d   = MEM;
                    end
                    CL_BEQ: begin
                        alu_op   = 2'b01;
                        pc_src   = 1'b1;
                        pc_write = bus.zero;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = (class_q == CL_ST);
                if (bus.mem_ready) begin
                    if (class_q == CL_LD) begin
                        state_d = WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end else if (tmo_last) begin
                    mem_err = 1'b1;
                    state_d = FETCH;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == CL_LD);
                retire     = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase

        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            i_or_d     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            illegal    = 1'b0;
            mem_err    = 1'b0;
            retire     = 1'b0;
        end

        // Any non-wait cycle (or an abort) restarts the consecutive-wait count.
        waiting  = mem_req && !bus.mem_ready;
        tmo_d    = (waiting && !mem_err) ? tmo_q + TMO_W'(1) : '0;
        retire_d = retire ? retire_q + CNT_W'(1) : retire_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            class_q  <= CL_R;
            tmo_q    <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            class_q  <= class_d;
            tmo_q    <= tmo_d;
            retire_q <= retire_d;
        end
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.i_or_d       = i_or_d;
    assign bus.ir_write     = ir_write;
    assign bus.pc_write     = pc_write;
    assign bus.pc_src       = pc_src;
    assign bus.reg_write    = reg_write;
    assign bus.mem_to_reg   = mem_to_reg;
    assign bus.alu_src_a    = alu_src_a;
    assign bus.alu_src_b    = alu_src_b;
    assign bus.alu_op       = alu_op;
    assign bus.illegal      = illegal;
    assign bus.mem_err      = mem_err;
    assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Cycle-by-cycle vector table for the multi-cycle sequencer, compared through a
// scoreboard queue, plus a hand-written timeout sequence.
module tb_multicycle_sequencer;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 2;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_ILL = 7'b1111111;

    // {req,we,iod}_{irw,pcw,pcs}_{rw,m2r,asa}_{asb}_{aop}_{ill,err}
    localparam logic [14:0] ZERO    = 15'b000_000_000_00_00_00;
    localparam logic [14:0] F_WAIT  = 15'b100_000_000_01_00_00;
    localparam logic [14:0] F_DONE  = 15'b100_110_000_01_00_00;
    localparam logic [14:0] F_ABRT  = 15'b100_000_000_01_00_01;
    localparam logic [14:0] DEC     = 15'b000_000_000_10_00_00;
    localparam logic [14:0] DEC_ILL = 15'b000_000_000_10_00_10;
    localparam logic [14:0] EX_R    = 15'b000_000_001_00_10_00;
    localparam logic [14:0] EX_I    = 15'b000_000_001_10_10_00;
    localparam logic [14:0] EX_LS   = 15'b000_000_001_10_00_00;
    localparam logic [14:0] EX_B1   = 15'b000_011_001_00_01_00;
    localparam logic [14:0] EX_B0   = 15'b000_001_001_00_01_00;
    localparam logic [14:0] MEM_LD  = 15'b101_000_000_00_00_00;
    localparam logic [14:0] MEM_LDE = 15'b101_000_000_00_00_01;
    localparam logic [14:0] MEM_ST  = 15'b111_000_000_00_00_00;
    localparam logic [14:0] WB_R    = 15'b000_000_100_00_00_00;
    localparam logic [14:0] WB_LD   = 15'b000_000_110_00_00_00;

    typedef struct packed {
        logic       rst;
        logic [6:0] op;
        logic       z;
        logic       rdy;
        logic [14:0] eo;
        logic [CNT_W-1:0] ec;
    } vec_t;

    typedef struct packed {
        logic [14:0]      eo;
        logic [CNT_W-1:0] ec;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];
    exp_t sb[$];

    multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

    multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [14:0] obs;
    assign obs = {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.pc_write,
                  bus.pc_src, bus.reg_write, bus.mem_to_reg, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.illegal, bus.mem_err};

    task automatic add(input logic rst, input logic [6:0] op, input logic z,
                       input logic rdy, input logic [14:0] eo, input logic [CNT_W-1:0] ec);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.eo = eo; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        logic seen_irw;

        reset = 1'b1;
        bus.opcode = OP_R;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        // R-type, no wait states
        add(1, OP_R,   0, 1, ZERO,    0);
        add(0, OP_R,   0, 1, F_DONE,  0);
        add(0, OP_R,   0, 1, DEC,     0);
        add(0, OP_R,   0, 1, EX_R,    0);
        add(0, OP_R,   0, 1, WB_R,    0);
        // I-type
        add(0, OP_I,   0, 1, F_DONE,  1);
        add(0, OP_I,   0, 1, DEC,     1);
        add(0, OP_I,   0, 1, EX_I,    1);
        add(0, OP_I,   0, 1, WB_R,    1);
        // LD with three MEM wait cycles
        add(0, OP_LD,  0, 1, F_DONE,  2);
        add(0, OP_LD,  0, 1, DEC,     2);
        add(0, OP_LD,  0, 1, EX_LS,   2);
        add(0, OP_LD,  0, 0, MEM_LD,  2);
        add(0, OP_LD,  0, 0, MEM_LD,  2);
        add(0, OP_LD,  0, 0, MEM_LD,  2);
        add(0, OP_LD,  0, 1, MEM_LD,  2);
        add(0, OP_LD,  0, 1, WB_LD,   2);
        // BEQ taken (retire wraps 3 -> 0), then not taken
        add(0, OP_BEQ, 1, 1, F_DONE,  3);
        add(0, OP_BEQ, 1, 1, DEC,     3);
        add(0, OP_BEQ, 1, 1, EX_B1,   3);
        add(0, OP_BEQ, 0, 1, F_DONE,  0);
        add(0, OP_BEQ, 0, 1, DEC,     0);
        add(0, OP_BEQ, 0, 1, EX_B0,   0);
        // illegal opcode, then R with mem_ready low outside FETCH/MEM
        add(0, OP_ILL, 0, 1, F_DONE,  1);
        add(0, OP_ILL, 0, 1, DEC_ILL, 1);
        add(0, OP_R,   0, 1, F_DONE,  1);
        add(0, OP_R,   0, 0, DEC,     1);
        add(0, OP_R,   0, 0, EX_R,    1);
        add(0, OP_R,   0, 0, WB_R,    1);
        // fetch timeout after 4 waits
        add(0, OP_ST,  0, 0, F_WAIT,  2);
        add(0, OP_ST,  0, 0, F_WAIT,  2);
        add(0, OP_ST,  0, 0, F_WAIT,  2);
        add(0, OP_ST,  0, 0, F_ABRT,  2);
        // ST completing on the cycle the 4th wait would have been
        add(0, OP_ST,  0, 1, F_DONE,  2);
        add(0, OP_ST,  0, 1, DEC,     2);
        add(0, OP_ST,  0, 1, EX_LS,   2);
        add(0, OP_ST,  0, 0, MEM_ST,  2);
        add(0, OP_ST,  0, 0, MEM_ST,  2);
        add(0, OP_ST,  0, 0, MEM_ST,  2);
        add(0, OP_ST,  0, 1, MEM_ST,  2);
        // LD timeout in MEM, no retire
        add(0, OP_LD,  0, 1, F_DONE,  3);
        add(0, OP_LD,  0, 1, DEC,     3);
        add(0, OP_LD,  0, 1, EX_LS,   3);
        add(0, OP_LD,  0, 0, MEM_LD,  3);
        add(0, OP_LD,  0, 0, MEM_LD,  3);
        add(0, OP_LD,  0, 0, MEM_LD,  3);
        add(0, OP_LD,  0, 0, MEM_LDE, 3);
        add(0, OP_ST,  0, 1, F_DONE,  3);
        // reset in MEM of ST, then a clean ST, then reset in FETCH
        add(0, OP_ST,  0, 1, DEC,     3);
        add(0, OP_ST,  0, 1, EX_LS,   3);
        add(1, OP_ST,  0, 0, ZERO,    3);
        add(0, OP_ST,  0, 0, F_WAIT,  0);
        add(0, OP_ST,  0, 1, F_DONE,  0);
        add(0, OP_ST,  0, 1, DEC,     0);
        add(0, OP_ST,  0, 1, EX_LS,   0);
        add(0, OP_ST,  0, 1, MEM_ST,  0);
        add(1, OP_R,   0, 1, ZERO,    1);
        add(0, OP_R,   0, 1, F_DONE,  0);
        add(0, OP_R,   0, 1, DEC,     0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            reset         = vecs[i].rst;
            bus.opcode    = vecs[i].op;
            bus.zero      = vecs[i].z;
            bus.mem_ready = vecs[i].rdy;
            sb.push_back({vecs[i].eo, vecs[i].ec});
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (obs !== e.eo) begin
                bad++;
                $display("FAIL row%0d outputs got=%b exp=%b", i, obs, e.eo);
            end
            total++;
            if (bus.retire_count !== e.ec) begin
                bad++;
                $display("FAIL row%0d retire_count got=%0d exp=%0d", i, bus.retire_count, e.ec);
            end
        end

        // hand sequence: mem_ready stuck low from the first fetch after reset
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        n = 0;
        seen_irw = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.ir_write) seen_irw = 1'b1;
            if (bus.mem_err || n >= 20) break;
            @(posedge clk);
            #1;
        end
        chk("timeout_cycles", n, MEM_TIMEOUT);
        chk("timeout_no_irw", {31'b0, seen_irw}, 0);
        chk("timeout_retire", {30'b0, bus.retire_count}, 0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("refetch_irw", {31'b0, bus.ir_write}, 1);
        chk("refetch_err", {31'b0, bus.mem_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
